scp_lsu: RTL and testbench
==========================

SCP_LSU -- requirements
Module: scp_lsu

Interface
REQ-001 SHALL have parameter X_LEN, default 32, meaning datapath and address width; only 32 is supported.
REQ-002 SHALL have ports as follows: clk_i  in  1  clock, all state on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous and active-low.
REQ-004 load_i  in  1  current instruction is a load (opcode 0000011).
REQ-005 store_i  in  1  current instruction is a store (controller write enable).
REQ-006 func3_i  in  3  instr[14:12]: access size and signedness.
REQ-007 addr_i  in  X_LEN  effective byte address (ALU result).
REQ-008 wdata_i  in  X_LEN  store data (rs2).
REQ-009 stall_o  out  1  hold PC and suppress register write while high.
REQ-010 rdata_o  out  X_LEN  aligned, extended load result for writeback.
REQ-011 err_o  out  1  misaligned or illegal-func3 access, one cycle.
REQ-012 mem_req_o  out  1  bus request; mem_we_o  out  1  write strobe.
REQ-013 mem_addr_o  out  X_LEN  word address, bits [1:0] forced to 0; mem_be_o  out  4  byte enables; mem_wdata_o  out  X_LEN  lane-replicated write data.
REQ-014 mem_gnt_i  in  1  request accepted; mem_rvalid_i  in  1  response valid (reads and writes); mem_rdata_i  in  X_LEN  read word.

Function
REQ-015 SHALL implement FSM with states IDLE, REQ, WAIT, DONE.
REQ-016 IDLE: a legal access (load_i or store_i, aligned, legal func3) SHALL register addr, be, wdata, we, func3 and go to REQ.
REQ-017 stall_o SHALL be combinational: 1 in IDLE when a legal access is present, 1 in REQ and WAIT, 0 in DONE.
REQ-018 REQ: mem_req_o SHALL be 1 with all bus fields held stable from the registered copy until mem_gnt_i=1.
REQ-019 REQ with mem_gnt_i=1: if mem_rvalid_i=1 in the same cycle, go to DONE; otherwise go to WAIT.
REQ-020 WAIT: mem_req_o SHALL be 0; on mem_rvalid_i=1 capture the load result and go to DONE; otherwise remain in WAIT with no timeout.
REQ-021 DONE SHALL last exactly one cycle with stall_o=0 so the core writes back and advances, then return to IDLE; the access is not re-issued.
REQ-022 Minimum load/store latency SHALL be 3 cycles from IDLE acceptance to DONE, with gnt and rvalid in the REQ cycle.
REQ-023 Illegal func3 SHALL be: load 3, 6, 7; store 3 to 7.
REQ-024 Misaligned SHALL be: half with addr[0]=1; word with addr[1:0]!=0.
REQ-025 An illegal or misaligned access in IDLE SHALL pulse err_o=1, keep stall_o=0, issue no bus request and stay in IDLE.
REQ-026 load_i and store_i both high SHALL be treated as illegal.
REQ-027 Store encoding, with o=addr[1:0]:
- SB: be=0001<<o, wdata={4{wdata[7:0]}}
- SH: be=0011<<o, wdata={2{wdata[15:0]}}
- SW: be=1111, wdata unchanged
REQ-028 Loads SHALL use mem_we_o=0 and be=1111; rdata_o SHALL select the lane by o:
- LB/LBU: byte at 8*o, sign-/zero-extended
- LH/LHU: half at 16*o[1], sign-/zero-extended
- LW: full word
REQ-029 rdata_o SHALL be registered, valid in DONE, and held until the next captured load; stores SHALL NOT change it.
REQ-030 mem_rvalid_i or mem_gnt_i in IDLE or DONE SHALL be ignored.

Reset
REQ-031 rst_ni=0 SHALL asynchronously force: state IDLE; mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0; rdata_o=0; err_o=0.
REQ-032 Reset during REQ or WAIT SHALL abandon the access; a late rvalid after reset SHALL be ignored.
REQ-033 After reset release, stall_o SHALL follow REQ-017 from the first cycle.

Verification
REQ-034 LB addr=0x1003, mem word 0x80FF1234, gnt+rvalid in the REQ cycle -> be=1111, mem_addr=0x1000, rdata_o=0xFFFFFF80 in DONE, stall high 2 cycles.
REQ-035 SH addr=0x2002, wdata=0x0000BEEF, gnt after 2 wait cycles, rvalid 1 cycle later -> be=1100, mem_wdata=0xBEEFBEEF, we=1, fields stable throughout REQ, one DONE cycle.
REQ-036 LW addr=0x3001 -> err_o=1 for one cycle, stall_o=0, mem_req_o never asserted.
REQ-037 LHU addr=0x4002, word 0x9ABC5678, rvalid 5 cycles after gnt -> stall held through WAIT, rdata_o=0x00009ABC.
REQ-038 rst_ni low during WAIT, then rvalid pulse -> all outputs reset, FSM IDLE, rdata_o stays 0.
REQ-039 Back-to-back LW then SW -> each performs exactly one bus transaction; second request starts the cycle after the first DONE.

Source files
------------

// File: rtl/scp_lsu.sv
// scp_lsu: load/store unit for a single-cycle-issue RISC-V core.
// Stalls the core while a bus access is in flight and aligns load data.
module scp_lsu #(
    parameter int X_LEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             store_i,
    input  logic [2:0]       func3_i,
    input  logic [X_LEN-1:0] addr_i,
    input  logic [X_LEN-1:0] wdata_i,
    output logic             stall_o,
    output logic [X_LEN-1:0] rdata_o,
    output logic             err_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [X_LEN-1:0] mem_addr_o,
    output logic [3:0]       mem_be_o,
    output logic [X_LEN-1:0] mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [X_LEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [X_LEN-1:0] addr_q, addr_d;
    logic [X_LEN-1:0] wdata_q, wdata_d;
    logic [X_LEN-1:0] rdata_q, rdata_d;
    logic [3:0]       be_q, be_d;
    logic             we_q, we_d;
    logic [2:0]       func3_q, func3_d;
    logic             err_q, err_d;

    logic             access;
    logic             illegal;
    logic             misalign;
    logic             legal;
    logic [3:0]       be_new;
    logic [X_LEN-1:0] wdata_new;
    logic [X_LEN-1:0] shifted;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [X_LEN-1:0] ld_val;

    // Classify the incoming access and build its byte enables and lane data.
    always_comb begin
        access   = load_i | store_i;
        illegal  = 1'b0;
        misalign = 1'b0;
        be_new   = 4'b1111;
        wdata_new = wdata_i;
        if (load_i && store_i) begin
            illegal = 1'b1;
        end else if (load_i) begin
            illegal = (func3_i == 3'd3) | (func3_i[2:1] == 2'b11);
        end else if (store_i) begin
            illegal = func3_i[2] | (func3_i[1:0] == 2'b11);
        end
        unique case (func3_i[1:0])
            2'b01:   misalign = addr_i[0];
            2'b10:   misalign = (addr_i[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
        legal = access & ~illegal & ~misalign;
        if (store_i) begin
            unique case (func3_i[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << addr_i[1:0];
                    wdata_new = {(X_LEN/8){wdata_i[7:0]}};
                end
                2'b01: begin
                    be_new    = 4'b0011 << addr_i[1:0];
                    wdata_new = {(X_LEN/16){wdata_i[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = wdata_i;
                end
            endcase
        end
    end

    // Pick the addressed lane of the read word and extend it.
    always_comb begin
        shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};
        ld_byte = shifted[7:0];
        ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        unique case (func3_q)
            3'd0:    ld_val = {{(X_LEN-8){ld_byte[7]}}, ld_byte};
            3'd1:    ld_val = {{(X_LEN-16){ld_half[15]}}, ld_half};
            3'd4:    ld_val = {{(X_LEN-8){1'b0}}, ld_byte};
            3'd5:    ld_val = {{(X_LEN-16){1'b0}}, ld_half};
            default: ld_val = mem_rdata_i;
        endcase
    end

    // Access sequencing: accept, request, wait for response, release the core.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        we_d    = we_q;
        func3_d = func3_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (legal) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_new;
                    be_d    = be_new;
                    we_d    = store_i;
                    func3_d = func3_i;
                    state_d = REQ;
                end else if (access) begin
                    err_d = 1'b1;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if (mem_rvalid_i) begin
                        state_d = DONE;
                        if (!we_q) rdata_d = ld_val;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = ld_val;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered access copy; reset abandons any open access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            func3_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            func3_q <= func3_d;
            err_q   <= err_d;
        end
    end

    assign stall_o     = ((state_q == IDLE) && legal) ||
                         (state_q == REQ) || (state_q == WAIT);
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = {addr_q[X_LEN-1:2], 2'b00};
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_scp_lsu.sv
// tb_scp_lsu: directed vectors and multi-cycle sequences for scp_lsu.
module tb_scp_lsu;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        load_i, store_i;
    logic [2:0]  func3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int failures = 0;
    int txn_cnt = 0;
    int base;

    scp_lsu #(.X_LEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .load_i(load_i), .store_i(store_i),
        .func3_i(func3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Count accepted bus requests.
    always @(posedge clk) begin
        if (mem_req_o && mem_gnt_i) txn_cnt <= txn_cnt + 1;
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic        err;
        logic [3:0]  be;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        load_i = v.ld;
        store_i = v.st;
        func3_i = v.f3;
        addr_i = v.addr;
        wdata_i = v.wdata;
        mem_rdata_i = v.word;
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b1;
        smp;
        chk($sformatf("v%0d_stall_idle", idx), {31'd0, stall_o},
            {31'd0, ~v.err});
        chk($sformatf("v%0d_req_idle", idx), {31'd0, mem_req_o}, 32'd0);
        cyc;
        if (v.err) begin
            load_i = 1'b0;
            store_i = 1'b0;
            smp;
            chk($sformatf("v%0d_err", idx), {31'd0, err_o}, 32'd1);
            chk($sformatf("v%0d_err_req", idx), {31'd0, mem_req_o}, 32'd0);
            chk($sformatf("v%0d_err_stall", idx), {31'd0, stall_o}, 32'd0);
            cyc;
            smp;
            chk($sformatf("v%0d_err_clr", idx), {31'd0, err_o}, 32'd0);
            cyc;
        end else begin
            smp;
            chk($sformatf("v%0d_req", idx), {31'd0, mem_req_o}, 32'd1);
            chk($sformatf("v%0d_be", idx), {28'd0, mem_be_o}, {28'd0, v.be});
            chk($sformatf("v%0d_we", idx), {31'd0, mem_we_o}, {31'd0, v.we});
            chk($sformatf("v%0d_addr", idx), mem_addr_o, v.maddr);
            chk($sformatf("v%0d_wdata", idx), mem_wdata_o, v.mwdata);
            chk($sformatf("v%0d_stall_req", idx), {31'd0, stall_o}, 32'd1);
            cyc;
            smp;
            chk($sformatf("v%0d_stall_done", idx), {31'd0, stall_o}, 32'd0);
            chk($sformatf("v%0d_req_done", idx), {31'd0, mem_req_o}, 32'd0);
            chk($sformatf("v%0d_rdata", idx), rdata_o, v.rdata);
            cyc;
            load_i = 1'b0;
            store_i = 1'b0;
            smp;
            chk($sformatf("v%0d_no_reissue", idx), {31'd0, stall_o}, 32'd0);
            cyc;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h1003, 32'h0, 32'h80FF1234,
                     1'b0, 4'hF, 1'b0, 32'h1000, 32'h0, 32'hFFFFFF80};
        vecs[1]  = '{1'b1, 1'b0, 3'd4, 32'h1002, 32'h0, 32'h80FF1234,
                     1'b0, 4'hF, 1'b0, 32'h1000, 32'h0, 32'h000000FF};
        vecs[2]  = '{1'b1, 1'b0, 3'd1, 32'h2000, 32'h0, 32'h12348001,
                     1'b0, 4'hF, 1'b0, 32'h2000, 32'h0, 32'hFFFF8001};
        vecs[3]  = '{1'b1, 1'b0, 3'd5, 32'h4002, 32'h0, 32'h9ABC5678,
                     1'b0, 4'hF, 1'b0, 32'h4000, 32'h0, 32'h00009ABC};
        vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'h3004, 32'h0, 32'hDEADBEEF,
                     1'b0, 4'hF, 1'b0, 32'h3004, 32'h0, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 1'b1, 3'd0, 32'h5001, 32'h123456A5, 32'h11111111,
                     1'b0, 4'h2, 1'b1, 32'h5000, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 1'b1, 3'd1, 32'h2002, 32'h0000BEEF, 32'h22222222,
                     1'b0, 4'hC, 1'b1, 32'h2000, 32'hBEEFBEEF, 32'hDEADBEEF};
        vecs[7]  = '{1'b0, 1'b1, 3'd2, 32'h6000, 32'hCAFEF00D, 32'h33333333,
                     1'b0, 4'hF, 1'b1, 32'h6000, 32'hCAFEF00D, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 1'b0, 3'd2, 32'h3001, 32'h0, 32'h0,
                     1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'd1, 32'h2001, 32'h0, 32'h0,
                     1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'd3, 32'h0, 32'h0, 32'h0,
                     1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'd4, 32'h0, 32'h0, 32'h0,
                     1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 3'd2, 32'h0, 32'h0, 32'h0,
                     1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 3'd0, 32'h7000, 32'h0, 32'h0000007F,
                     1'b0, 4'hF, 1'b0, 32'h7000, 32'h0, 32'h0000007F};

        rst_ni = 1'b0;
        load_i = 1'b0;
        store_i = 1'b0;
        func3_i = 3'd0;
        addr_i = '0;
        wdata_i = '0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;

        repeat (2) cyc;
        smp;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_be", {28'd0, mem_be_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        cyc;
        rst_ni = 1'b1;
        cyc;

        // SH with grant after two wait cycles, response one cycle later
        store_i = 1'b1;
        func3_i = 3'd1;
        addr_i = 32'h2002;
        wdata_i = 32'h0000BEEF;
        smp;
        chk("sh_stall_idle", {31'd0, stall_o}, 32'd1);
        chk("sh_req_idle", {31'd0, mem_req_o}, 32'd0);
        cyc;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_gnt_i = 1'b1;
            smp;
            chk($sformatf("sh_req_%0d", i), {31'd0, mem_req_o}, 32'd1);
            chk($sformatf("sh_be_%0d", i), {28'd0, mem_be_o}, 32'hC);
            chk($sformatf("sh_addr_%0d", i), mem_addr_o, 32'h2000);
            chk($sformatf("sh_wdata_%0d", i), mem_wdata_o, 32'hBEEFBEEF);
            chk($sformatf("sh_we_%0d", i), {31'd0, mem_we_o}, 32'd1);
            chk($sformatf("sh_stall_%0d", i), {31'd0, stall_o}, 32'd1);
            cyc;
        end
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1;
        smp;
        chk("sh_wait_req", {31'd0, mem_req_o}, 32'd0);
        chk("sh_wait_stall", {31'd0, stall_o}, 32'd1);
        cyc;
        mem_rvalid_i = 1'b0;
        smp;
        chk("sh_done_stall", {31'd0, stall_o}, 32'd0);
        chk("sh_done_req", {31'd0, mem_req_o}, 32'd0);
        cyc;
        store_i = 1'b0;
        smp;
        chk("sh_idle_stall", {31'd0, stall_o}, 32'd0);
        chk("sh_idle_req", {31'd0, mem_req_o}, 32'd0);
        chk("sh_rdata_kept", rdata_o, 32'd0);
        cyc;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;

        // LHU with response five cycles after grant
        load_i = 1'b1;
        func3_i = 3'd5;
        addr_i = 32'h4002;
        mem_rdata_i = 32'h9ABC5678;
        mem_gnt_i = 1'b1;
        smp;
        chk("lhu_stall_idle", {31'd0, stall_o}, 32'd1);
        cyc;
        smp;
        chk("lhu_req", {31'd0, mem_req_o}, 32'd1);
        cyc;
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) mem_rvalid_i = 1'b1;
            smp;
            chk($sformatf("lhu_wait_stall_%0d", i), {31'd0, stall_o}, 32'd1);
            chk($sformatf("lhu_wait_req_%0d", i), {31'd0, mem_req_o}, 32'd0);
            cyc;
        end
        mem_rvalid_i = 1'b0;
        smp;
        chk("lhu_done_stall", {31'd0, stall_o}, 32'd0);
        chk("lhu_rdata", rdata_o, 32'h00009ABC);
        cyc;
        load_i = 1'b0;
        cyc;

        // Back-to-back LW then SW
        base = txn_cnt;
        load_i = 1'b1;
        func3_i = 3'd2;
        addr_i = 32'h8000;
        mem_rdata_i = 32'h01020304;
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b1;
        smp;
        chk("b2b_lw_stall", {31'd0, stall_o}, 32'd1);
        cyc;
        smp;
        chk("b2b_lw_req", {31'd0, mem_req_o}, 32'd1);
        cyc;
        smp;
        chk("b2b_lw_done", {31'd0, stall_o}, 32'd0);
        chk("b2b_lw_rdata", rdata_o, 32'h01020304);
        cyc;
        load_i = 1'b0;
        store_i = 1'b1;
        addr_i = 32'h8004;
        wdata_i = 32'h0BADF00D;
        smp;
        chk("b2b_sw_stall", {31'd0, stall_o}, 32'd1);
        chk("b2b_sw_req_idle", {31'd0, mem_req_o}, 32'd0);
        cyc;
        smp;
        chk("b2b_sw_req", {31'd0, mem_req_o}, 32'd1);
        chk("b2b_sw_addr", mem_addr_o, 32'h8004);
        chk("b2b_sw_wdata", mem_wdata_o, 32'h0BADF00D);
        cyc;
        smp;
        chk("b2b_sw_done", {31'd0, stall_o}, 32'd0);
        chk("b2b_sw_rdata", rdata_o, 32'h01020304);
        cyc;
        store_i = 1'b0;
        smp;
        chk("b2b_txn_count", txn_cnt - base, 32'd2);
        cyc;

        // Reset while waiting, then a late response
        load_i = 1'b1;
        func3_i = 3'd2;
        addr_i = 32'h9000;
        mem_rdata_i = 32'h55555555;
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b0;
        cyc;
        cyc;
        mem_gnt_i = 1'b0;
        smp;
        chk("rw_wait_req", {31'd0, mem_req_o}, 32'd0);
        chk("rw_wait_stall", {31'd0, stall_o}, 32'd1);
        #1;
        rst_ni = 1'b0;
        load_i = 1'b0;
        #1;
        chk("rw_req", {31'd0, mem_req_o}, 32'd0);
        chk("rw_we", {31'd0, mem_we_o}, 32'd0);
        chk("rw_be", {28'd0, mem_be_o}, 32'd0);
        chk("rw_addr", mem_addr_o, 32'd0);
        chk("rw_wdata", mem_wdata_o, 32'd0);
        chk("rw_rdata", rdata_o, 32'd0);
        chk("rw_err", {31'd0, err_o}, 32'd0);
        chk("rw_stall", {31'd0, stall_o}, 32'd0);
        cyc;
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1;
        smp;
        chk("rw_late_stall", {31'd0, stall_o}, 32'd0);
        chk("rw_late_req", {31'd0, mem_req_o}, 32'd0);
        cyc;
        mem_rvalid_i = 1'b0;
        smp;
        chk("rw_late_rdata", rdata_o, 32'd0);
        chk("rw_late_req2", {31'd0, mem_req_o}, 32'd0);
        chk("rw_late_stall2", {31'd0, stall_o}, 32'd0);
        cyc;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
